servo_multi_channel_ctrl: RTL and testbench

Parametrised successor to the four-servo arm controller. It maps a joystick sample to a pulse-width target for the selected channel, with clamping, a deadband and fixed-point scaling. It debounces the channel-select buttons and slew-limits every channel's command once per PWM frame. A home mode drives all channels to the centre position. Its cmd_bus feeds the existing per-channel servo PWM generators.

---
 rtl/servo_multi_channel_ctrl_pkg.sv | 22 ++
 rtl/servo_multi_channel_ctrl_btn_debounce.sv | 48 ++++
 rtl/servo_multi_channel_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_servo_multi_channel_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_multi_channel_ctrl_pkg.sv
// Shared constants, FSM state type and the elaboration-time scale helper for
// the multi-channel servo controller.
package servo_pkg;

    localparam int DEF_PW_MIN      = 650;
    localparam int DEF_PW_MAX      = 2600;
    localparam int DEF_PW_CENTER   = 1500;
    localparam int FRAME_PERIOD_US = 20000;
    localparam int FRAME_RATE_HZ   = 50;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HOMING = 1'b1
    } state_t;

    // Q8 fixed-point gain from joystick counts to microseconds.
    function automatic int scale_q8(input int pw_min, input int pw_max,
                                    input int x_min, input int x_max);
        return ((pw_max - pw_min) << 8) / (x_max - x_min);
    endfunction

endpackage

// File: rtl/servo_multi_channel_ctrl_btn_debounce.sv
// One pushbutton: 2-FF synchroniser, stable-sample counter and a one-cycle
// pulse when the debounced level rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_rise
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    // The counter runs only while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/servo_multi_channel_ctrl.sv
// Multi-channel servo command generator: joystick mapping, debounced channel
// select, per-frame slew limiting and a home-to-centre mode.
module servo_multi_channel_ctrl
    import servo_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int X_W             = 10,
    parameter int X_MIN           = 228,
    parameter int X_MAX           = 830,
    parameter int PW_W            = 12,
    parameter int PW_MIN          = DEF_PW_MIN,
    parameter int PW_MAX          = DEF_PW_MAX,
    parameter int PW_CENTER       = DEF_PW_CENTER,
    parameter int STEP_US         = 20,
    parameter int DEADBAND        = 8,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [X_W-1:0]       x_sample,
    input  logic                 x_valid,
    input  logic [N_CH-1:0]      sel_btn,
    input  logic                 home_req,
    input  logic                 frame_tick,
    output logic [N_CH*PW_W-1:0] cmd_bus,
    output logic [N_CH-1:0]      sel_onehot,
    output logic [N_CH-1:0]      at_target,
    output logic                 homing
);

    localparam int              SCALE_Q8 = scale_q8(PW_MIN, PW_MAX, X_MIN, X_MAX);
    localparam int              PROD_W   = X_W + PW_W + 9;
    localparam logic [X_W-1:0]  XMIN_V   = X_W'(X_MIN);
    localparam logic [X_W-1:0]  XMAX_V   = X_W'(X_MAX);
    localparam logic [PW_W-1:0] PWMIN_V  = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0] PWMAX_V  = PW_W'(PW_MAX);
    localparam logic [PW_W-1:0] PWCTR_V  = PW_W'(PW_CENTER);
    localparam logic [PW_W-1:0] STEP_V   = PW_W'(STEP_US);
    localparam logic [PW_W-1:0] DB_V     = PW_W'(DEADBAND);

    state_t r_state;
    state_t w_state_next;
    logic   w_home_start;
    logic   w_run;

    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_sel_next;
    logic [N_CH-1:0] r_sel;

    logic              r_v1;
    logic              r_v2;
    logic [X_W-1:0]    w_xc;
    logic [X_W-1:0]    r_xc;
    logic [X_W-1:0]    w_xoff;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_sum;
    logic [PW_W-1:0]   w_map;
    logic [PW_W-1:0]   r_mapped;

    // ---------------- channel select ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .i_clk (CLK),
                .i_rst (RST),
                .i_btn (sel_btn[gi]),
                .o_rise(w_rise[gi])
            );
        end
    endgenerate

    // Scan from the top so the lowest rising index is the one that sticks.
    always_comb begin
        w_sel_next = r_sel;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_sel_next = N_CH'(1) << i;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel <= N_CH'(1);
        end else begin
            r_sel <= w_sel_next;
        end
    end

    // ---------------- mapping pipeline ----------------
    assign w_xc = (x_sample < XMIN_V) ? XMIN_V :
                  (x_sample > XMAX_V) ? XMAX_V : x_sample;

    assign w_xoff = r_xc - XMIN_V;
    assign w_prod = PROD_W'(w_xoff) * PROD_W'(SCALE_Q8);
    assign w_sum  = (w_prod >> 8) + PROD_W'(PW_MIN);

    // The Q8 gain rounds down, so the top of the range is pinned explicitly.
    always_comb begin
        w_map = w_sum[PW_W-1:0];
        if (r_xc == XMAX_V || w_sum > PROD_W'(PW_MAX)) begin
            w_map = PWMAX_V;
        end else if (w_sum < PROD_W'(PW_MIN)) begin
            w_map = PWMIN_V;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_xc     <= XMIN_V;
            r_mapped <= PWCTR_V;
        end else begin
            r_v1     <= x_valid;
            r_v2     <= r_v1;
            r_xc     <= w_xc;
            r_mapped <= w_map;
        end
    end

    // ---------------- mode FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_home_start = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (home_req) begin
                    w_state_next = ST_HOMING;
                    w_home_start = 1'b1;
                end
            end
            ST_HOMING: begin
                if (&at_target) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    assign w_run  = (r_state == ST_RUN);
    assign homing = (r_state == ST_HOMING);

    // ---------------- per-channel target and slew ----------------
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PW_W-1:0] r_cmd;
            logic [PW_W-1:0] r_target;
            logic            w_up;
            logic [PW_W-1:0] w_gap;
            logic [PW_W-1:0] w_mgap;
            logic            w_write;

            assign w_up    = (r_target > r_cmd);
            assign w_gap   = w_up ? (r_target - r_cmd) : (r_cmd - r_target);
            assign w_mgap  = (r_mapped > r_target) ? (r_mapped - r_target)
                                                   : (r_target - r_mapped);
            assign w_write = w_run && r_v2 && r_sel[gi] && (w_mgap >= DB_V);

            // A home request overrides a joystick write landing on the same edge.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_target <= PWCTR_V;
                end else if (w_home_start) begin
                    r_target <= PWCTR_V;
                end else if (w_write) begin
                    r_target <= r_mapped;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cmd <= PWCTR_V;
                end else if (frame_tick) begin
                    if (w_gap <= STEP_V) begin
                        r_cmd <= r_target;
                    end else if (w_up) begin
                        r_cmd <= r_cmd + STEP_V;
                    end else begin
                        r_cmd <= r_cmd - STEP_V;
                    end
                end
            end

            assign cmd_bus[gi*PW_W +: PW_W] = r_cmd;
            assign at_target[gi]            = (r_cmd == r_target);
        end
    endgenerate

    assign sel_onehot = r_sel;

endmodule

// File: tb/tb_servo_multi_channel_ctrl.sv
// Scoreboard bench for servo_multi_channel_ctrl: directed scenarios followed
// by random operations, checked against an arithmetic reference model.
module tb_servo_multi_channel_ctrl;

   localparam int N_CH = 4;
   localparam int X_W  = 10;
   localparam int PW_W = 12;
   localparam int DEB  = 4;

   localparam int OP_SAMPLE = 0;
   localparam int OP_TICK   = 1;
   localparam int OP_HOME   = 2;
   localparam int OP_BTN    = 3;
   localparam int OP_RESET  = 4;

   logic                 CLK = 1'b0;
   logic                 RST = 1'b0;
   logic [X_W-1:0]       x_sample = '0;
   logic                 x_valid = 1'b0;
   logic [N_CH-1:0]      sel_btn = '0;
   logic                 home_req = 1'b0;
   logic                 frame_tick = 1'b0;
   logic [N_CH*PW_W-1:0] cmd_bus;
   logic [N_CH-1:0]      sel_onehot;
   logic [N_CH-1:0]      at_target;
   logic                 homing;

   servo_multi_channel_ctrl #(
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .x_sample  (x_sample),
      .x_valid   (x_valid),
      .sel_btn   (sel_btn),
      .home_req  (home_req),
      .frame_tick(frame_tick),
      .cmd_bus   (cmd_bus),
      .sel_onehot(sel_onehot),
      .at_target (at_target),
      .homing    (homing)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string tag;
      int    cmd[N_CH];
      int    sel;
      int    at;
      int    hom;
   } exp_t;

   exp_t sbq[$];
   logic chk = 1'b0;
   logic finalChk = 1'b0;
   int   nChecks = 0;
   int   nFails = 0;

   // Reference model state
   int mCmd[N_CH];
   int mTgt[N_CH];
   int mSel;
   int mHoming;

   function automatic int mapX(input int x);
      int xc, m, scale;
      scale = ((2600 - 650) * 256) / (830 - 228);
      xc = (x < 228) ? 228 : ((x > 830) ? 830 : x);
      if (xc == 830) return 2600;
      m = 650 + (((xc - 228) * scale) / 256);
      if (m > 2600) m = 2600;
      if (m < 650) m = 650;
      return m;
   endfunction

   function automatic int allEqual();
      for (int i = 0; i < N_CH; i++) if (mCmd[i] != mTgt[i]) return 0;
      return 1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < N_CH; i++) begin
         mCmd[i] = 1500;
         mTgt[i] = 1500;
      end
      mSel = 0;
      mHoming = 0;
   endtask

   task automatic modelSample(input int x);
      int m, d;
      if (mHoming == 0) begin
         m = mapX(x);
         d = m - mTgt[mSel];
         if (d < 0) d = -d;
         if (d >= 8) mTgt[mSel] = m;
      end
   endtask

   task automatic modelTick();
      int d;
      for (int i = 0; i < N_CH; i++) begin
         d = mTgt[i] - mCmd[i];
         if (d <= 20 && d >= -20) mCmd[i] = mTgt[i];
         else if (d > 0) mCmd[i] = mCmd[i] + 20;
         else mCmd[i] = mCmd[i] - 20;
      end
      if (mHoming != 0 && allEqual() != 0) mHoming = 0;
   endtask

   task automatic modelHome();
      if (mHoming == 0) begin
         for (int i = 0; i < N_CH; i++) mTgt[i] = 1500;
         mHoming = 1;
         if (allEqual() != 0) mHoming = 0;
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      int at;
      e.tag = tag;
      at = 0;
      for (int i = 0; i < N_CH; i++) begin
         e.cmd[i] = mCmd[i];
         if (mCmd[i] == mTgt[i]) at = at | (1 << i);
      end
      e.sel = 1 << mSel;
      e.at  = at;
      e.hom = mHoming;
      sbq.push_back(e);
      chk = 1'b1;
      cycle(1);
      chk = 1'b0;
   endtask

   // arg for OP_BTN: mask in bits [3:0], hold length in bits [15:8]
   task automatic applyStimulus(input int op, input int arg);
      int mask, hold;
      case (op)
         OP_SAMPLE: begin
            x_sample = X_W'(arg);
            x_valid = 1'b1;
            cycle(1);
            x_valid = 1'b0;
            cycle(4);
            modelSample(arg);
         end
         OP_TICK: begin
            frame_tick = 1'b1;
            cycle(1);
            frame_tick = 1'b0;
            cycle(3);
            modelTick();
         end
         OP_HOME: begin
            home_req = 1'b1;
            cycle(1);
            home_req = 1'b0;
            cycle(3);
            modelHome();
         end
         OP_BTN: begin
            mask = arg & 15;
            hold = (arg >> 8) & 255;
            sel_btn = N_CH'(mask);
            cycle(hold);
            sel_btn = '0;
            cycle(12);
            if (hold >= 6 && mask != 0) begin
               for (int i = N_CH - 1; i >= 0; i--) if (((mask >> i) & 1) != 0) mSel = i;
            end
         end
         default: begin
            RST = 1'b1;
            cycle(2);
            RST = 1'b0;
            cycle(1);
            modelReset();
         end
      endcase
   endtask

   task automatic compareField(input string name, input int act, input int expv);
      nChecks++;
      if (act != expv) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Monitor: pops one expected record per observation strobe.
   always @(negedge CLK) begin
      exp_t e;
      if (chk) begin
         if (sbq.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboard_empty: got 0 records expected 1");
         end else begin
            e = sbq.pop_front();
            for (int i = 0; i < N_CH; i++)
               compareField($sformatf("%s.cmd%0d", e.tag, i),
                            int'(cmd_bus[i*PW_W +: PW_W]), e.cmd[i]);
            compareField({e.tag, ".sel"}, int'(sel_onehot), e.sel);
            compareField({e.tag, ".at_target"}, int'(at_target), e.at);
            compareField({e.tag, ".homing"}, int'(homing), e.hom);
         end
      end
      if (finalChk) begin
         compareField("leftover_records", sbq.size(), 0);
      end
   end

   int boundary[8] = '{0, 227, 228, 229, 829, 830, 831, 1023};
   int holds[6]    = '{1, 2, 3, 6, 7, 8};

   initial begin
      int r, x;
      modelReset();
      $display("[TB] start");

      // Reset and idle frames
      applyStimulus(OP_RESET, 0);
      checkOutput("reset");
      for (int i = 0; i < 3; i++) applyStimulus(OP_TICK, 0);
      checkOutput("idle");

      // Full-scale deflection and 55-frame ramp on channel 0
      applyStimulus(OP_SAMPLE, 830);
      checkOutput("max_target");
      for (int i = 0; i < 55; i++) begin
         applyStimulus(OP_TICK, 0);
         checkOutput($sformatf("ramp%0d", i));
      end

      // Mid-scale value, deadband hold, low clamp
      applyStimulus(OP_SAMPLE, 529);
      for (int i = 0; i < 60; i++) applyStimulus(OP_TICK, 0);
      checkOutput("mid_529");
      applyStimulus(OP_SAMPLE, 531);
      checkOutput("deadband");
      applyStimulus(OP_SAMPLE, 100);
      for (int i = 0; i < 60; i++) applyStimulus(OP_TICK, 0);
      checkOutput("clamp_low");

      // Debounce: short press ignored, long press accepted, lowest index wins
      applyStimulus(OP_BTN, (3 << 8) | 4);
      checkOutput("btn_short");
      applyStimulus(OP_BTN, (6 << 8) | 4);
      checkOutput("btn_long");
      applyStimulus(OP_BTN, (7 << 8) | 10);
      checkOutput("btn_tie");

      // Homing from both ends of travel, joystick ignored meanwhile
      applyStimulus(OP_SAMPLE, 830);
      applyStimulus(OP_BTN, (7 << 8) | 4);
      applyStimulus(OP_SAMPLE, 100);
      for (int i = 0; i < 60; i++) applyStimulus(OP_TICK, 0);
      checkOutput("pre_home");
      applyStimulus(OP_HOME, 0);
      checkOutput("home_start");
      applyStimulus(OP_SAMPLE, 400);
      checkOutput("home_ignore");
      for (int i = 0; i < 55; i++) begin
         applyStimulus(OP_TICK, 0);
         checkOutput($sformatf("home%0d", i));
      end

      // Reset mid-ramp with a sample still in the pipeline
      applyStimulus(OP_BTN, (7 << 8) | 1);
      applyStimulus(OP_SAMPLE, 830);
      for (int i = 0; i < 15; i++) applyStimulus(OP_TICK, 0);
      checkOutput("pre_reset_1800");
      x_sample = X_W'(600);
      x_valid = 1'b1;
      cycle(1);
      x_valid = 1'b0;
      RST = 1'b1;
      cycle(1);
      RST = 1'b0;
      modelReset();
      cycle(3);
      checkOutput("mid_reset");
      for (int i = 0; i < 3; i++) applyStimulus(OP_TICK, 0);
      checkOutput("post_reset");

      // Random operations
      for (int n = 0; n < 160; n++) begin
         r = $urandom_range(0, 99);
         if (r < 40) begin
            if ($urandom_range(0, 3) == 0) x = boundary[$urandom_range(0, 7)];
            else x = $urandom_range(0, 1023);
            applyStimulus(OP_SAMPLE, x);
         end else if (r < 75) begin
            repeat ($urandom_range(1, 5)) applyStimulus(OP_TICK, 0);
         end else if (r < 82) begin
            applyStimulus(OP_HOME, 0);
         end else if (r < 98) begin
            applyStimulus(OP_BTN, (holds[$urandom_range(0, 5)] << 8) | $urandom_range(1, 15));
         end else begin
            applyStimulus(OP_RESET, 0);
         end
         checkOutput($sformatf("rand%0d", n));
      end

      cycle(2);
      finalChk = 1'b1;
      cycle(1);
      finalChk = 1'b0;
      cycle(1);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
